// File: rtl/axis_pkt_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkt_pkg
// Shared widths, the stored beat layout and the output FSM state type for
// the AXI-Stream packetizer slice.
// ---------------------------------------------------------------------------
package axis_pkt_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_DEST_W = 8;
    localparam int AXIS_USER_W = 4;

    // One FIFO entry: payload word plus its end-of-packet flag.
    typedef struct packed {
        logic                   last;
        logic [AXIS_DATA_W-1:0] data;
    } beat_t;

    // TUSER marker carried on the first beat of every packet.
    localparam logic [AXIS_USER_W-1:0] USER_FIRST = 4'b0001;

    typedef enum logic {
        FIRST = 1'b0,
        BODY  = 1'b1
    } pkt_state_e;

    // Destination lives in the top byte of a packet's first word.
    function automatic logic [AXIS_DEST_W-1:0] dest_of(input beat_t b);
        return b.data[AXIS_DATA_W-1 -: AXIS_DEST_W];
    endfunction

endpackage

// File: rtl/axis_packetizer_if.sv
// ---------------------------------------------------------------------------
// AXIStream
// AXI-Stream bundle used on the packetizer's output side.
//   master modport : drives TVALID, TDATA, TLAST, TDEST, TUSER; samples TREADY
//   slave  modport : the mirror image
// ---------------------------------------------------------------------------
interface AXIStream
    import axis_pkt_pkg::*;
();

    logic                   TVALID;
    logic                   TREADY;
    logic [AXIS_DATA_W-1:0] TDATA;
    logic                   TLAST;
    logic [AXIS_DEST_W-1:0] TDEST;
    logic [AXIS_USER_W-1:0] TUSER;

    modport master (
        output TVALID,
        output TDATA,
        output TLAST,
        output TDEST,
        output TUSER,
        input  TREADY
    );

    modport slave (
        input  TVALID,
        input  TDATA,
        input  TLAST,
        input  TDEST,
        input  TUSER,
        output TREADY
    );

endinterface

// File: rtl/pkt_fifo.sv
// ---------------------------------------------------------------------------
// pkt_fifo
// Synchronous first-word-fall-through FIFO of DEPTH beat_t entries.
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en_i     : write wr_beat_i this cycle (ignored when full)
//   rd_en_i     : pop the head this cycle (ignored when empty)
//   rd_beat_o   : current head entry, valid whenever empty_o is low
//   level_o     : number of entries held (0..DEPTH)
//   empty_o     : no entries held
//   full_o      : DEPTH entries held
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
// ---------------------------------------------------------------------------
module pkt_fifo
    import axis_pkt_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en_i,
    input  beat_t                      wr_beat_i,
    input  logic                       rd_en_i,
    output beat_t                      rd_beat_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    beat_t          mem_q [DEPTH];
    logic [AW-1:0]  wrPtr_q, wrPtr_d;
    logic [AW-1:0]  rdPtr_q, rdPtr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           wrEn;
    logic           rdEn;

    assign empty_o   = (level_q == '0);
    assign full_o    = (level_q == LW'(DEPTH));
    assign wrEn      = wr_en_i && !full_o;
    assign rdEn      = rd_en_i && !empty_o;
    assign rd_beat_o = mem_q[rdPtr_q];
    assign level_o   = level_q;

    // Storage array carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_q[wrPtr_q] <= wr_beat_i;
        end
    end

    // Pointers wrap naturally at DEPTH; a simultaneous push and pop keeps
    // the level unchanged.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (wrEn) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (rdEn) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({wrEn, rdEn})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/axis_packetizer.sv
// ---------------------------------------------------------------------------
// axis_packetizer
// Buffers upstream words in a FWFT FIFO and emits them as AXI-Stream packets,
// tagging each packet with TDEST taken from its first word and marking the
// first beat with TUSER = USER_FIRST.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : upstream word qualifier
//   in_ready    : FIFO can accept a word
//   in_data     : payload; bits [31:24] of a packet's first word = destination
//   in_last     : final word of a packet
//   m_axis      : AXI-Stream master output
//   fifo_level  : beats currently held
// Optional build macro AXIS_PACKETIZER_STORE_FORWARD_EN: hold a packet back
// until it is complete in the FIFO (with a cut-through fallback when the
// FIFO fills before any packet is complete). Default build is cut-through.
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module axis_packetizer
    import axis_pkt_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AXIS_DATA_W-1:0] in_data,
    input  logic                   in_last,
    AXIStream.master               m_axis,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int LW = $clog2(DEPTH) + 1;

    pkt_state_e             state_q, state_d;
    logic [AXIS_DEST_W-1:0] dest_q, dest_d;
    logic                   readyEn_q;
    beat_t                  wrBeat;
    beat_t                  headBeat;
    logic                   fifoEmpty;
    logic                   fifoFull;
    logic                   push;
    logic                   pop;
    logic                   releaseOk;

    assign wrBeat   = '{last: in_last, data: in_data};
    // readyEn_q keeps in_ready low through reset and for the edge that
    // releases it.
    assign in_ready = readyEn_q && !fifoFull;
    assign push     = in_valid && in_ready;
    assign pop      = releaseOk && m_axis.TREADY;

    pkt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (push),
        .wr_beat_i (wrBeat),
        .rd_en_i   (pop),
        .rd_beat_o (headBeat),
        .level_o   (fifo_level),
        .empty_o   (fifoEmpty),
        .full_o    (fifoFull)
    );

`ifdef AXIS_PACKETIZER_STORE_FORWARD_EN
    logic [LW-1:0] pktCnt_q, pktCnt_d;

    // Complete packets resident in the FIFO.
    always_comb begin
        pktCnt_d = pktCnt_q;
        case ({push && in_last, pop && headBeat.last})
            2'b10:   pktCnt_d = pktCnt_q + LW'(1);
            2'b01:   pktCnt_d = pktCnt_q - LW'(1);
            default: pktCnt_d = pktCnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pktCnt_q <= '0;
        end else begin
            pktCnt_q <= pktCnt_d;
        end
    end

    // A packet already in flight must finish; a full FIFO with no complete
    // packet would otherwise deadlock, so it falls back to cut-through.
    assign releaseOk = !fifoEmpty && ((pktCnt_q != '0) || (state_q == BODY) || fifoFull);
`else
    assign releaseOk = !fifoEmpty;
`endif

    // Output FSM: in FIRST the head's own destination byte is presented
    // directly, and latched on transfer so later beats repeat it.
    always_comb begin
        state_d       = state_q;
        dest_d        = dest_q;
        m_axis.TVALID = releaseOk;
        m_axis.TDATA  = headBeat.data;
        m_axis.TLAST  = headBeat.last;
        m_axis.TDEST  = dest_q;
        m_axis.TUSER  = '0;
        case (state_q)
            FIRST: begin
                m_axis.TDEST = dest_of(headBeat);
                m_axis.TUSER = USER_FIRST;
                if (pop) begin
                    dest_d  = dest_of(headBeat);
                    state_d = headBeat.last ? FIRST : BODY;
                end
            end
            BODY: begin
                if (pop && headBeat.last) begin
                    state_d = FIRST;
                end
            end
            default: state_d = FIRST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FIRST;
            dest_q    <= '0;
            readyEn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            readyEn_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_packetizer.sv
// ---------------------------------------------------------------------------
// tb_axis_packetizer
// Directed packet scenarios with constant expectations, followed by random
// traffic checked against a queue-based packet model.
// ---------------------------------------------------------------------------
module tb_axis_packetizer;
    import axis_pkt_pkg::*;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [7:0]  dest;
        logic [3:0]  user;
    } obs_t;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data  = '0;
    logic          in_last  = 1'b0;
    logic [LW-1:0] fifo_level;

    AXIStream axisIf ();

    int   vectors     = 0;
    int   miscompares = 0;
    obs_t gotQ [$];
    obs_t expQ [$];
    bit   mFirst;
    bit   mOutBody;
    logic [7:0] mDest;

    axis_packetizer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .m_axis     (axisIf),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic obs_t sampleOut();
        obs_t o;
        o.data = axisIf.TDATA;
        o.last = axisIf.TLAST;
        o.dest = axisIf.TDEST;
        o.user = axisIf.TUSER;
        return o;
    endfunction

    // Packet model: destination and TUSER follow from the input framing.
    function automatic void modelPush(input logic [31:0] d, input logic l);
        obs_t b;
        b.data = d;
        b.last = l;
        if (mFirst) begin
            mDest  = d[31:24];
            b.user = 4'b0001;
        end else begin
            b.user = 4'b0000;
        end
        b.dest = mDest;
        mFirst = l;
        expQ.push_back(b);
    endfunction

    // One cycle: drive at posedge+1, record any transfer at negedge.
    task automatic tick(input logic v, input logic [31:0] d, input logic l, input logic r);
        in_valid      = v;
        in_data       = d;
        in_last       = l;
        axisIf.TREADY = r;
        @(negedge clk);
        if (axisIf.TVALID && axisIf.TREADY) gotQ.push_back(sampleOut());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid      = 1'b0;
        axisIf.TREADY = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready got %b want 0", in_ready);
        end
        vectors++;
        if (axisIf.TVALID !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_tvalid got %b want 0", axisIf.TVALID);
        end
        vectors++;
        if (fifo_level !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_level got %0d want 0", fifo_level);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL release_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_three_word();
        logic [44:0] e [3];
        obs_t        g;
        logic        wantValid;
        e[0] = {32'hA500_0001, 1'b0, 8'hA5, 4'h1};
        e[1] = {32'h0000_0002, 1'b0, 8'hA5, 4'h0};
        e[2] = {32'h0000_0003, 1'b1, 8'hA5, 4'h0};
        gotQ.delete();
        vectors++;
        if (axisIf.TVALID !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_tvalid got %b want 0", axisIf.TVALID);
        end
        tick(1'b1, 32'hA500_0001, 1'b0, 1'b1);
`ifdef AXIS_PACKETIZER_STORE_FORWARD_EN
        wantValid = 1'b0;
`else
        wantValid = 1'b1;
`endif
        vectors++;
        if (axisIf.TVALID !== wantValid) begin
            miscompares++;
            $display("[TB] FAIL first_write_latency got %b want %b", axisIf.TVALID, wantValid);
        end
        tick(1'b1, 32'h0000_0002, 1'b0, 1'b1);
        tick(1'b1, 32'h0000_0003, 1'b1, 1'b1);
        vectors++;
        if (axisIf.TVALID !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL last_write_latency got %b want 1", axisIf.TVALID);
        end
        repeat (4) tick(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (gotQ.size() != 3) begin
            miscompares++;
            $display("[TB] FAIL three_word_count got %0d want 3", gotQ.size());
        end
        for (int i = 0; i < 3 && i < gotQ.size(); i++) begin
            g = gotQ[i];
            vectors++;
            if ({g.data, g.last, g.dest, g.user} !== e[i]) begin
                miscompares++;
                $display("[TB] FAIL three_word_beat%0d got %h want %h", i, {g.data, g.last, g.dest, g.user}, e[i]);
            end
        end
    endtask

    task automatic test_single();
        logic [44:0] e [2];
        obs_t        g;
        e[0] = {32'h7F00_BEEF, 1'b1, 8'h7F, 4'h1};
        e[1] = {32'h3C00_0001, 1'b1, 8'h3C, 4'h1};
        gotQ.delete();
        tick(1'b1, 32'h7F00_BEEF, 1'b1, 1'b1);
        tick(1'b1, 32'h3C00_0001, 1'b1, 1'b1);
        repeat (3) tick(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (gotQ.size() != 2) begin
            miscompares++;
            $display("[TB] FAIL single_count got %0d want 2", gotQ.size());
        end
        for (int i = 0; i < 2 && i < gotQ.size(); i++) begin
            g = gotQ[i];
            vectors++;
            if ({g.data, g.last, g.dest, g.user} !== e[i]) begin
                miscompares++;
                $display("[TB] FAIL single_beat%0d got %h want %h", i, {g.data, g.last, g.dest, g.user}, e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [5];
        logic        wl [5];
        logic [44:0] e [5];
        obs_t        cur;
        obs_t        prev;
        bit          stalled;
        int          wi;
        w[0] = 32'h1100_0001; w[1] = 32'h0000_0002; w[2] = 32'h0000_0003;
        w[3] = 32'h2200_0004; w[4] = 32'h0000_0005;
        wl[0] = 1'b0; wl[1] = 1'b0; wl[2] = 1'b1; wl[3] = 1'b0; wl[4] = 1'b1;
        e[0] = {w[0], 1'b0, 8'h11, 4'h1};
        e[1] = {w[1], 1'b0, 8'h11, 4'h0};
        e[2] = {w[2], 1'b1, 8'h11, 4'h0};
        e[3] = {w[3], 1'b0, 8'h22, 4'h1};
        e[4] = {w[4], 1'b1, 8'h22, 4'h0};
        gotQ.delete();
        wi      = 0;
        stalled = 1'b0;
        for (int c = 0; c < 30; c++) begin
            in_valid = (wi < 5);
            if (wi < 5) begin
                in_data = w[wi];
                in_last = wl[wi];
            end
            axisIf.TREADY = (c % 2 == 0);
            @(negedge clk);
            cur = sampleOut();
            if (stalled) begin
                vectors++;
                if (axisIf.TVALID !== 1'b1 ||
                    {cur.data, cur.last, cur.dest, cur.user} !== {prev.data, prev.last, prev.dest, prev.user}) begin
                    miscompares++;
                    $display("[TB] FAIL stall_hold cycle %0d got v=%b %h want v=1 %h", c, axisIf.TVALID,
                             {cur.data, cur.last, cur.dest, cur.user}, {prev.data, prev.last, prev.dest, prev.user});
                end
            end
            stalled = (axisIf.TVALID === 1'b1) && (axisIf.TREADY === 1'b0);
            prev    = cur;
            if (axisIf.TVALID && axisIf.TREADY) gotQ.push_back(cur);
            if (in_valid && in_ready) wi++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        vectors++;
        if (gotQ.size() != 5) begin
            miscompares++;
            $display("[TB] FAIL b2b_count got %0d want 5", gotQ.size());
        end
        for (int i = 0; i < 5 && i < gotQ.size(); i++) begin
            cur = gotQ[i];
            vectors++;
            if ({cur.data, cur.last, cur.dest, cur.user} !== e[i]) begin
                miscompares++;
                $display("[TB] FAIL b2b_beat%0d got %h want %h", i, {cur.data, cur.last, cur.dest, cur.user}, e[i]);
            end
        end
    endtask

    task automatic test_fill_wrap();
        obs_t        g;
        logic [44:0] want;
        int          wi;
        gotQ.delete();
        wi = 0;
        axisIf.TREADY = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (wi < 20);
            in_data  = 32'hC300_0000 | 32'(wi);
            in_last  = (wi == 19);
            @(negedge clk);
            vectors++;
            if (in_ready !== (c < 16)) begin
                miscompares++;
                $display("[TB] FAIL fill_in_ready cycle %0d got %b want %b", c, in_ready, (c < 16));
            end
            if (in_valid && in_ready) wi++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (fifo_level !== LW'(16)) begin
            miscompares++;
            $display("[TB] FAIL fill_level got %0d want 16", fifo_level);
        end
        axisIf.TREADY = 1'b1;
        for (int c = 0; c < 40; c++) begin
            in_valid = (wi < 20);
            in_data  = 32'hC300_0000 | 32'(wi);
            in_last  = (wi == 19);
            @(negedge clk);
            if (axisIf.TVALID && axisIf.TREADY) gotQ.push_back(sampleOut());
            if (in_valid && in_ready) wi++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        vectors++;
        if (gotQ.size() != 20) begin
            miscompares++;
            $display("[TB] FAIL wrap_count got %0d want 20", gotQ.size());
        end
        for (int i = 0; i < 20 && i < gotQ.size(); i++) begin
            g    = gotQ[i];
            want = {32'hC300_0000 | 32'(i), (i == 19), 8'hC3, (i == 0) ? 4'h1 : 4'h0};
            vectors++;
            if ({g.data, g.last, g.dest, g.user} !== want) begin
                miscompares++;
                $display("[TB] FAIL wrap_beat%0d got %h want %h", i, {g.data, g.last, g.dest, g.user}, want);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [44:0] e [4];
        obs_t        g;
        e[0] = {32'h5A00_0001, 1'b0, 8'h5A, 4'h1};
        e[1] = {32'h0000_0002, 1'b0, 8'h5A, 4'h0};
        e[2] = {32'h6600_0001, 1'b0, 8'h66, 4'h1};
        e[3] = {32'h6600_0002, 1'b1, 8'h66, 4'h0};
        gotQ.delete();
        tick(1'b1, 32'h5A00_0001, 1'b0, 1'b0);
        tick(1'b1, 32'h0000_0002, 1'b0, 1'b0);
        tick(1'b1, 32'h0000_0003, 1'b0, 1'b0);
        tick(1'b1, 32'h0000_0004, 1'b1, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        axisIf.TREADY = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (axisIf.TVALID !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_tvalid got %b want 0", axisIf.TVALID);
        end
        vectors++;
        if (fifo_level !== '0) begin
            miscompares++;
            $display("[TB] FAIL midrst_level got %0d want 0", fifo_level);
        end
        for (int i = 0; i < 2 && i < gotQ.size(); i++) begin
            g = gotQ[i];
            vectors++;
            if ({g.data, g.last, g.dest, g.user} !== e[i]) begin
                miscompares++;
                $display("[TB] FAIL midrst_pre_beat%0d got %h want %h", i, {g.data, g.last, g.dest, g.user}, e[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        gotQ.delete();
        tick(1'b1, 32'h6600_0001, 1'b0, 1'b1);
        tick(1'b1, 32'h6600_0002, 1'b1, 1'b1);
        repeat (3) tick(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (gotQ.size() != 2) begin
            miscompares++;
            $display("[TB] FAIL midrst_post_count got %0d want 2", gotQ.size());
        end
        for (int i = 0; i < 2 && i < gotQ.size(); i++) begin
            g = gotQ[i];
            vectors++;
            if ({g.data, g.last, g.dest, g.user} !== e[i+2]) begin
                miscompares++;
                $display("[TB] FAIL midrst_post_beat%0d got %h want %h", i, {g.data, g.last, g.dest, g.user}, e[i+2]);
            end
        end
    endtask

`ifdef AXIS_PACKETIZER_STORE_FORWARD_EN
    task automatic test_store_forward();
        gotQ.delete();
        tick(1'b1, 32'h4400_0001, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        tick(1'b1, 32'h0000_0002, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        tick(1'b1, 32'h0000_0003, 1'b0, 1'b1);
        vectors++;
        if (axisIf.TVALID !== 1'b0 || gotQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL sf_hold got v=%b beats=%0d want v=0 beats=0", axisIf.TVALID, gotQ.size());
        end
        tick(1'b1, 32'h0000_0004, 1'b1, 1'b1);
        vectors++;
        if (axisIf.TVALID !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL sf_release got %b want 1", axisIf.TVALID);
        end
        repeat (6) tick(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (gotQ.size() != 4) begin
            miscompares++;
            $display("[TB] FAIL sf_count got %0d want 4", gotQ.size());
        end
    endtask
`endif

    task automatic test_random(input int cycles);
        logic [LW-1:0] expLevel;
        logic          expReady;
        logic          expValid;
        obs_t          cur;
        obs_t          h;
        int            nLast;
        expQ.delete();
        mFirst   = 1'b1;
        mOutBody = 1'b0;
        mDest    = '0;
        for (int c = 0; c < cycles; c++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            in_data       = $urandom;
            in_last       = ($urandom_range(0, 4) == 0);
            axisIf.TREADY = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            expLevel = LW'(expQ.size());
            expReady = (expQ.size() < DEPTH);
            nLast    = 0;
            foreach (expQ[i]) if (expQ[i].last) nLast++;
`ifdef AXIS_PACKETIZER_STORE_FORWARD_EN
            expValid = (expQ.size() > 0) && (nLast > 0 || mOutBody || expQ.size() == DEPTH);
`else
            expValid = (expQ.size() > 0) && (nLast >= 0);
`endif
            vectors++;
            if (in_ready !== expReady) begin
                miscompares++;
                $display("[TB] FAIL rnd_in_ready cycle %0d got %b want %b", c, in_ready, expReady);
            end
            vectors++;
            if (fifo_level !== expLevel) begin
                miscompares++;
                $display("[TB] FAIL rnd_level cycle %0d got %0d want %0d", c, fifo_level, expLevel);
            end
            vectors++;
            if (axisIf.TVALID !== expValid) begin
                miscompares++;
                $display("[TB] FAIL rnd_tvalid cycle %0d got %b want %b", c, axisIf.TVALID, expValid);
            end
            if (expValid) begin
                cur = sampleOut();
                h   = expQ[0];
                vectors++;
                if ({cur.data, cur.last, cur.dest, cur.user} !== {h.data, h.last, h.dest, h.user}) begin
                    miscompares++;
                    $display("[TB] FAIL rnd_beat cycle %0d got %h want %h", c,
                             {cur.data, cur.last, cur.dest, cur.user}, {h.data, h.last, h.dest, h.user});
                end
                if (axisIf.TREADY) begin
                    mOutBody = !h.last;
                    void'(expQ.pop_front());
                end
            end
            if (in_valid && expReady) modelPush(in_data, in_last);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        axisIf.TREADY = 1'b0;
        test_reset();
        test_three_word();
        test_single();
        test_back_to_back();
        test_fill_wrap();
        test_reset_mid_packet();
`ifdef AXIS_PACKETIZER_STORE_FORWARD_EN
        test_store_forward();
`endif
        test_random(400);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_packetizer.md
AXIS_PACKETIZER -- requirements
Module: axis_packetizer

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the FIFO depth in beats; it SHALL be a power of two and at least 2.
REQ-002 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-003 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 in_valid  input  1  SHALL qualify an upstream word.
REQ-005 in_ready  output  1  SHALL indicate that the FIFO can accept a word.
REQ-006 in_data  input  32  SHALL carry the payload word; bits [31:24] of a packet's first word are its destination.
REQ-007 in_last  input  1  SHALL mark the final word of a packet.
REQ-008 m_axis  AXIStream.master  --  SHALL drive TVALID, TDATA[31:0], TLAST, TDEST[7:0] and TUSER[3:0], and SHALL sample TREADY.
REQ-009 fifo_level  output  $clog2(DEPTH)+1  SHALL report the number of beats held.

Function
REQ-010 A word SHALL be written when in_valid && in_ready; in_ready = (fifo_level < DEPTH).
REQ-011 TDATA and TLAST SHALL equal the FIFO head word and its stored last flag; TVALID SHALL be asserted whenever the head is releasable (see REQ-016).
REQ-012 A beat SHALL transfer on TVALID && TREADY; the FIFO SHALL pop in the same cycle.
REQ-013 Output FSM states:
- FIRST: next beat starts a packet.
- BODY: within a packet.
- Transitions: FIRST->BODY on a transfer with TLAST=0; BODY->FIRST on a transfer with TLAST=1; FIRST->FIRST on a transfer with TLAST=1 (single-beat packet).
REQ-014 In FIRST, TDEST SHALL equal head[31:24] combinationally, and TUSER SHALL be 4'b0001. On transfer, dest_q SHALL capture head[31:24].
REQ-015 In BODY, TDEST SHALL equal dest_q and TUSER SHALL be 4'b0000; TDEST SHALL be constant across the whole packet.
REQ-016 Without the configuration macro, the head SHALL be releasable whenever the FIFO is non-empty (cut-through). Latency from input write to TVALID SHALL be 1 cycle.
REQ-017 A simultaneous push and pop SHALL leave fifo_level unchanged; push when full SHALL be impossible (in_ready=0). A pop when empty SHALL be impossible (TVALID=0).
REQ-018 Read and write pointers SHALL wrap modulo DEPTH, with no bubble at wrap.
REQ-019 While TVALID=1 and TREADY=0, TDATA, TLAST, TDEST and TUSER SHALL hold stable.

Reset
REQ-020 On rst_n low, asynchronously:
- pointers=0, fifo_level=0, state=FIRST, dest_q=0
- TVALID=0, in_ready=0
- any partially sent packet is discarded.
REQ-021 in_ready SHALL rise in the first cycle after rst_n deassertion.

Configuration
REQ-022 Macro AXIS_PACKETIZER_STORE_FORWARD_EN, when defined, SHALL gate release on pkt_cnt>0 or state==BODY.
- pkt_cnt counts complete packets in the FIFO: +1 on an in_last write, -1 on a TLAST transfer, both in the same cycle => unchanged.
REQ-023 With the macro defined, if the FIFO is full and pkt_cnt==0, release SHALL be forced (cut-through fallback) to avoid deadlock.
REQ-024 With the macro defined, write-to-TVALID latency SHALL be 1 cycle after the in_last write.
REQ-025 Without the macro, pkt_cnt logic SHALL not exist.

Structure
REQ-026 Package axis_pkt_pkg SHALL hold:
- AXIS_DATA_W=32, AXIS_DEST_W=8, AXIS_USER_W=4
- typedef beat_t {logic last; logic [31:0] data;}
- USER_FIRST=4'b0001.
REQ-027 Sub-module pkt_fifo (synchronous, DEPTH x beat_t, first-word-fall-through) SHALL implement storage; axis_packetizer SHALL own the FSM, dest_q and pkt_cnt.

Verification
REQ-028 Write 3 words 0xA5000001, 0x00000002, 0x00000003 (last on the 3rd) with TREADY=1 -> 3 beats; TDEST=0xA5 on all, TUSER=1,0,0; TLAST on beat 3 only.
REQ-029 Single-word packet 0x7F00BEEF with last -> one beat with TLAST=1, TUSER=1, TDEST=0x7F; FSM remains FIRST.
REQ-030 Back-to-back packets with dest 0x11 then 0x22, TREADY toggling 1/0 -> outputs stable while stalled; second packet TDEST=0x22 with TUSER=1 on its first beat.
REQ-031 DEPTH=16, TREADY=0, write 20 words -> in_ready=0 after 16; fifo_level=16; after TREADY=1 all 20 words arrive in order across wrap.
REQ-032 Assert rst_n low mid-packet (after 2 of 4 beats) -> TVALID=0 and fifo_level=0 immediately; the next packet starts with TUSER=1.
REQ-033 With AXIS_PACKETIZER_STORE_FORWARD_EN, write 4 words with gaps -> TVALID stays 0 until 1 cycle after the last write; an 18-word packet into DEPTH=16 -> release forced at full, no deadlock.
